// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package loader_pkg;
  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERROR} state_t;
  localparam logic [31:0] HALT_WORD_DEF  = 32'hFFFF_FFFF;
  localparam int          BYTES_PER_WORD = 4;
endpackage

// File: rtl/byte_assembler.sv
// Shifts received bytes into a big-endian word; flags the byte that completes it.
module byte_assembler import loader_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [7:0]        data,
  output logic [DATA_W-1:0] word,
  output logic              word_valid
);
  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  logic [CNT_W-1:0] cnt;

  // Combinational so the FSM can enter WRITE on the same edge that takes the last byte.
  assign word_valid = en && (cnt == CNT_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word <= '0;
      cnt  <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      word <= {word[DATA_W-9:0], data};
      cnt  <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/program_loader.sv
// Downloads a program from the UART into instruction memory, then hands the port to the CPU.
module program_loader import loader_pkg::*; #(
  parameter int                ADDR_W    = 6,
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] HALT_WORD = HALT_WORD_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  input  logic [ADDR_W-1:0] i_cpu_pc,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_we,
  output logic              o_cpu_enable,
  output logic              o_done,
  output logic              o_overflow,
  output logic [ADDR_W:0]   o_word_count
);
  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic              accept;
  logic              word_valid;

  // A byte arriving during WRITE already belongs to the next word; i_start drops any byte.
  assign accept = i_rx_valid && !i_start && (state == RECV || state == WRITE);

  byte_assembler #(.DATA_W(DATA_W)) u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (i_start),
    .en         (accept),
    .data       (i_rx_data),
    .word       (o_mem_wdata),
    .word_valid (word_valid)
  );

  assign o_mem_addr = (state == DONE) ? i_cpu_pc : wr_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      o_mem_we     <= 1'b0;
      o_cpu_enable <= 1'b0;
      o_done       <= 1'b0;
      o_overflow   <= 1'b0;
      o_word_count <= '0;
    end else if (i_start) begin
      state        <= RECV;
      wr_ptr       <= '0;
      o_mem_we     <= 1'b0;
      o_cpu_enable <= 1'b0;
      o_done       <= 1'b0;
      o_overflow   <= 1'b0;
      o_word_count <= '0;
    end else begin
      o_mem_we <= 1'b0;
      case (state)
        RECV: if (word_valid) begin
          state    <= WRITE;
          o_mem_we <= 1'b1;
        end
        WRITE: begin
          o_word_count <= o_word_count + 1'b1;
          if (o_mem_wdata == HALT_WORD) begin
            state        <= DONE;
            o_done       <= 1'b1;
            o_cpu_enable <= 1'b1;
          end else if (wr_ptr == '1) begin
            state      <= ERROR;
            o_overflow <= 1'b1;
          end else begin
            wr_ptr <= wr_ptr + 1'b1;
            state  <= RECV;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// Randomized scoreboard bench for program_loader against a byte-queue reference model.
module tb_program_loader;
  localparam int          ADDR_W = 6;
  localparam int          DATA_W = 32;
  localparam int          DEPTH  = 1 << ADDR_W;
  localparam logic [31:0] HALT   = 32'hFFFF_FFFF;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              i_start = 1'b0;
  logic [7:0]        i_rx_data = '0;
  logic              i_rx_valid = 1'b0;
  logic [ADDR_W-1:0] i_cpu_pc = '0;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic              o_mem_we, o_cpu_enable, o_done, o_overflow;
  logic [ADDR_W:0]   o_word_count;

  program_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .HALT_WORD(HALT)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_rx_data(i_rx_data),
    .i_rx_valid(i_rx_valid), .i_cpu_pc(i_cpu_pc), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_we(o_mem_we), .o_cpu_enable(o_cpu_enable),
    .o_done(o_done), .o_overflow(o_overflow), .o_word_count(o_word_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  // Reference model: a load collects accepted bytes four at a time.
  bit         m_active, m_done, m_ovf;
  int         m_addr, m_count;
  logic [7:0] m_bytes[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear(input bit active);
    m_active = active; m_done = 0; m_ovf = 0; m_addr = 0; m_count = 0;
    m_bytes.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [31:0] w;
    if (!m_active) return;
    m_bytes.push_back(b);
    if (m_bytes.size() == 4) begin
      w = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
      m_bytes.delete();
      exp_q.push_back({ADDR_W'(m_addr), w});
      m_count++;
      if (w == HALT) begin m_done = 1; m_active = 0; end
      else if (m_addr == DEPTH - 1) begin m_ovf = 1; m_active = 0; end
      else m_addr++;
    end
  endtask

  // All drivers run at posedge+1 so the DUT samples stable inputs.
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data = b; i_rx_valid = 1'b1;
    model_byte(b);
    @(posedge clk); #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int k = 0; k < 4; k++) begin
      send_byte(w[31-8*k -: 8]);
      if (gaps) idle($urandom_range(0, 2));
    end
  endtask

  task automatic start(input bit with_byte);
    i_start = 1'b1;
    if (with_byte) begin i_rx_valid = 1'b1; i_rx_data = 8'($urandom); end
    model_clear(1);
    @(posedge clk); #1;
    i_start = 1'b0; i_rx_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == HALT) w = 32'h0;
    return w;
  endfunction

  task automatic chk_status(input string tag);
    idle(3);
    chk({tag, "_done"},    64'(o_done),       64'(m_done));
    chk({tag, "_ovf"},     64'(o_overflow),   64'(m_ovf));
    chk({tag, "_cpu_en"},  64'(o_cpu_enable), 64'(m_done));
    chk({tag, "_count"},   64'(o_word_count), 64'(m_count));
    chk({tag, "_pending"}, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"},   64'(o_mem_addr),   64'(0));
    chk({tag, "_wdata"},  64'(o_mem_wdata),  64'(0));
    chk({tag, "_we"},     64'(o_mem_we),     64'(0));
    chk({tag, "_status"}, 64'({o_cpu_enable, o_done, o_overflow}), 64'(0));
    chk({tag, "_count"},  64'(o_word_count), 64'(0));
  endtask

  // Monitor: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (o_mem_we === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %h, none expected", o_mem_addr, o_mem_wdata);
      end else begin
        logic [ADDR_W+DATA_W-1:0] e;
        e = exp_q.pop_front();
        if ({o_mem_addr, o_mem_wdata} !== e) begin
          n_fail++;
          $display("FAIL write: got addr %0d data %h expected addr %0d data %h",
                   o_mem_addr, o_mem_wdata, e[ADDR_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    model_clear(0);
    @(posedge clk); #1;

    // Reset held while bytes stream in.
    repeat (6) send_byte(8'($urandom));
    chk_all_zero("reset_hold");
    rst = 1'b1;
    idle(2);
    chk_all_zero("reset_release");

    // Normal load.
    start(0);
    send_byte(8'h20); send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
    chk("we_latency", 64'(o_mem_we), 64'(1));
    send_word(HALT, 0);
    chk_status("normal");
    i_cpu_pc = 6'd3; #1;
    chk("pc_passthru", 64'(o_mem_addr), 64'(3));

    // Bytes in DONE are ignored while the CPU owns the address.
    for (int k = 0; k < 4; k++) begin
      send_byte(8'($urandom));
      i_cpu_pc = ADDR_W'($urandom); #1;
      chk("done_track_pc", 64'(o_mem_addr), 64'(i_cpu_pc));
    end
    chk_status("done_iso");
    start(0);
    chk("restart_done", 64'(o_done), 64'(0));
    chk("restart_cpu_en", 64'(o_cpu_enable), 64'(0));
    chk("restart_addr", 64'(o_mem_addr), 64'(0));

    // Restart mid-word, with a byte colliding with i_start.
    send_byte(8'hAA); send_byte(8'hBB);
    start(1);
    send_word(32'h1122_3344, 1);
    chk_status("restart_mid");

    // Overflow: every slot filled with non-halt words.
    start(0);
    for (int k = 0; k < DEPTH; k++) send_word(rand_word(), 1);
    chk_status("overflow");
    send_word(HALT, 0);
    chk_status("overflow_ignore");

    // Halt landing in the last slot.
    start(0);
    for (int k = 0; k < DEPTH - 1; k++) send_word(rand_word(), $urandom_range(0, 1) == 1);
    send_word(HALT, 1);
    chk_status("halt_last");

    // Reset in the middle of a word.
    start(0);
    send_word(rand_word(), 1);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    #2 rst = 1'b0;
    #1 chk_all_zero("reset_mid");
    model_clear(0);
    @(posedge clk); #1;
    rst = 1'b1;
    send_byte(8'h78);
    chk_status("reset_mid_after");
    start(0);
    send_word(32'hCAFE_0001, 1);
    send_word(HALT, 1);
    chk_status("reset_reload");

    // Random loads of varying length.
    for (int t = 0; t < 4; t++) begin
      int n;
      start($urandom_range(0, 1) == 1);
      n = $urandom_range(1, 10);
      for (int k = 0; k < n - 1; k++) send_word(rand_word(), 1);
      send_word(HALT, 1);
      chk_status("random_load");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/program_loader.md
# program_loader

Controller that owns the instruction memory's address/write port while a program is downloaded byte-by-byte from the UART receiver, then hands the read port to the CPU fetch stage. It assembles four received bytes into one 32-bit instruction and writes it to consecutive addresses starting at 0. It detects the halt word, blocks the CPU until loading completes, and flags programs that overflow the memory. It sits between the UART RX / debug unit, `instruction_memory`, and the pipeline's PC.

## Interface
Parameters:
- ADDR_W, 6, instruction memory address width (depth 2^ADDR_W words)
- DATA_W, 32, instruction width; fixed at 4 bytes
- HALT_WORD, 32'hFFFF_FFFF, end-of-program marker

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- i_start  in  1  one-cycle pulse; begins or restarts a load
- i_rx_data  in  8  received byte
- i_rx_valid  in  1  one-cycle strobe qualifying i_rx_data
- i_cpu_pc  in  ADDR_W  CPU fetch address
- o_mem_addr  out  ADDR_W  address to instruction memory
- o_mem_wdata  out  DATA_W  write data to instruction memory
- o_mem_we  out  1  write enable, one-cycle pulse per word
- o_cpu_enable  out  1  CPU may fetch/run
- o_done  out  1  program loaded (halt word written)
- o_overflow  out  1  memory filled without halt word
- o_word_count  out  ADDR_W+1  words written in current load, halt word included

## Operation
- States: IDLE, RECV, WRITE, DONE, ERROR.
- IDLE: i_start -> RECV. Bytes ignored.
- RECV: each i_rx_valid shifts the byte in; first byte is MSB (big-endian). After 4th byte -> WRITE.
- WRITE (exactly one cycle): o_mem_we=1, o_mem_addr=wr_ptr, o_mem_wdata=assembled word; o_word_count increments.
  - word == HALT_WORD -> DONE.
  - else wr_ptr == 2^ADDR_W-1 -> ERROR.
  - else wr_ptr+1 -> RECV.
- A byte strobed during WRITE is captured as byte 0 of the next word.
- DONE: o_done=1, o_cpu_enable=1, o_mem_addr=i_cpu_pc (combinational pass-through), o_mem_we=0. Bytes ignored.
- ERROR: o_overflow=1, o_cpu_enable=0. Bytes ignored.
- i_start in any state: clear wr_ptr, byte counter, o_word_count, o_done, o_overflow; go to RECV. A partial word is discarded. i_start has priority over a simultaneous i_rx_valid, which is dropped.
- Outside DONE, o_mem_addr = wr_ptr.

## Timing
- Reset (rst=0): state IDLE; all outputs 0; wr_ptr 0; byte counter 0. Takes effect immediately and is asynchronous. A write in progress is aborted with no o_mem_we pulse.
- o_mem_we is asserted the cycle after the clock edge that samples the 4th byte's i_rx_valid.
- o_done and o_cpu_enable rise on the cycle after the halt-word WRITE cycle.
- o_overflow rises on the cycle after the last-slot WRITE.
- The memory write is synchronous and completes on the WRITE-cycle edge.
- o_word_count updates at the end of the WRITE cycle.

## Structure
- Shared package `loader_pkg`: state enum (IDLE, RECV, WRITE, DONE, ERROR), HALT_WORD default, BYTES_PER_WORD=4.
- One sub-module `byte_assembler`: 32-bit shift register plus 2-bit byte counter, clear input. It emits word_valid on the 4th byte.
- FSM, pointer and address mux stay in `program_loader`.

## Test plan
- Reset: hold rst=0 while strobing bytes -> every output 0, no o_mem_we. Release -> IDLE, o_mem_addr=0.
- Normal load: i_start, then bytes 20 01 00 05, FF FF FF FF ->
  - o_mem_we pulses at addr 0 with 0x20010005, then at addr 1 with 0xFFFFFFFF;
  - o_done=1, o_cpu_enable=1, o_word_count=2;
  - i_cpu_pc=3 -> o_mem_addr=3 in the same cycle.
- Overflow: 64 non-halt words -> 64 writes at addr 0..63, then o_overflow=1, o_cpu_enable=0. Repeat with halt as the 64th word -> o_done=1, o_overflow=0.
- Restart mid-word: 2 bytes, i_start, then 11 22 33 44 -> single write at addr 0 of 0x11223344.
- Reset mid-operation: after 1 full word and 3 bytes, pulse rst=0 -> no second write, outputs 0. A new load then starts at addr 0.
- Post-done isolation: strobe bytes in DONE -> no o_mem_we, o_mem_addr still tracks i_cpu_pc. i_start -> o_done=0, o_cpu_enable=0, RECV.
